// File: rtl/systolic_row_feeder.sv
// Row feeder for the systolic array west edge: lockstep FIFO pops,
// diagonal skew (row r delayed r cycles), per-row valids and run completion.
module systolic_row_feeder #(
  parameter int ROWS       = 3,
  parameter int DATA_WIDTH = 24,
  parameter int CNT_W      = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic [CNT_W-1:0]           i_num_vec,
  input  logic                       i_stall,
  input  logic [ROWS-1:0]            i_buf_empty,
  input  logic [ROWS*DATA_WIDTH-1:0] i_buf_data,
  output logic [ROWS-1:0]            o_buf_rd,
  output logic [ROWS*DATA_WIDTH-1:0] o_row_data,
  output logic [ROWS-1:0]            o_row_valid,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int DCW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] vec_q;
  logic [CNT_W-1:0] num_q;
  logic [DCW-1:0]   drn_q;
  logic             zero_q;

  logic pop;
  logic last_pop;
  logic drain_end;

  assign pop = (state_q == FEED) & ~i_stall
             & ~|i_buf_empty;
  assign last_pop = pop
                  & (vec_q == num_q - CNT_W'(1));
  assign drain_end = (state_q == DRAIN) & ~i_stall
                   & (drn_q == '0);

  assign o_buf_rd = {ROWS{pop}};
  assign o_busy   = (state_q != IDLE);
  assign o_done   = zero_q | drain_end;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      num_q   <= '0;
      drn_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      // zero-length run completes one cycle after the start
      zero_q <= (state_q == IDLE) & i_start
              & ~i_stall & (i_num_vec == '0);
      if (!i_stall) begin
        unique case (state_q)
          IDLE: begin
            if (i_start && i_num_vec != '0) begin
              state_q <= FEED;
              num_q   <= i_num_vec;
              vec_q   <= '0;
            end
          end
          FEED: begin
            if (pop) begin
              vec_q <= vec_q + CNT_W'(1);
              if (last_pop) begin
                state_q <= DRAIN;
                drn_q   <= DCW'(ROWS - 1);
              end
            end
          end
          DRAIN: begin
            if (drn_q == '0) begin
              state_q <= IDLE;
            end else begin
              drn_q <= drn_q - DCW'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [DATA_WIDTH-1:0] d_q [0:r];
    logic [r:0]            v_q;

    // stage 0 takes the popped word or a bubble
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        for (int s = 0; s <= r; s++) begin
          d_q[s] <= '0;
        end
        v_q <= '0;
      end else if (!i_stall) begin
        d_q[0] <= pop
          ? i_buf_data[r*DATA_WIDTH +: DATA_WIDTH]
          : '0;
        v_q[0] <= pop;
        for (int s = 1; s <= r; s++) begin
          d_q[s] <= d_q[s-1];
          v_q[s] <= v_q[s-1];
        end
      end
    end

    assign o_row_data[r*DATA_WIDTH +: DATA_WIDTH] = d_q[r];
    assign o_row_valid[r] = v_q[r];
  end

endmodule

// File: tb/tb_systolic_row_feeder.sv
// Bench for systolic_row_feeder: directed scenarios plus random traffic
// checked cycle by cycle against a delay-line reference model.
module tb_systolic_row_feeder;

  localparam int ROWS = 3;
  localparam int DW   = 24;
  localparam int CW   = 8;
  localparam int W    = ROWS * DW;

  typedef logic [W-1:0] w_t;

  typedef struct packed {
    logic [ROWS-1:0] v;
    logic [W-1:0]    d;
  } inj_t;

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b1;
  logic            i_start = 1'b0;
  logic [CW-1:0]   i_num_vec = '0;
  logic            i_stall = 1'b0;
  logic [ROWS-1:0] i_buf_empty = '1;
  logic [W-1:0]    i_buf_data = '0;
  logic [ROWS-1:0] o_buf_rd;
  logic [W-1:0]    o_row_data;
  logic [ROWS-1:0] o_row_valid;
  logic            o_busy;
  logic            o_done;

  systolic_row_feeder #(
    .ROWS(ROWS),
    .DATA_WIDTH(DW),
    .CNT_W(CW)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_start(i_start),
    .i_num_vec(i_num_vec),
    .i_stall(i_stall),
    .i_buf_empty(i_buf_empty),
    .i_buf_data(i_buf_data),
    .o_buf_rd(o_buf_rd),
    .o_row_data(o_row_data),
    .o_row_valid(o_row_valid),
    .o_busy(o_busy),
    .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cyc = -1;
  int done_cnt = 0;
  int pops_seen = 0;

  logic [DW-1:0]   fq [ROWS][$];
  logic [ROWS-1:0] hold_empty = '0;
  inj_t            hist [$];
  int              m_mode = 0;
  int              m_left = 0;
  int              m_dl = 0;
  bit              m_zero = 1'b0;

  task automatic chk(input string tag,
                     input w_t got,
                     input w_t exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h",
             tag, cyc, got, exp);
    end
  endtask

  function automatic void load(input int n);
    for (int r = 0; r < ROWS; r++) begin
      fq[r].delete();
      for (int k = 0; k < n; k++)
        fq[r].push_back(DW'(256 * r + k));
    end
  endfunction

  function automatic void refill();
    for (int r = 0; r < ROWS; r++)
      while (fq[r].size() < 4)
        fq[r].push_back(DW'($urandom));
  endfunction

  function automatic void clr_obs();
    done_cyc  = -1;
    done_cnt  = 0;
    pops_seen = 0;
  endfunction

  task automatic step(input bit st,
                      input logic [CW-1:0] n,
                      input bit sl);
    logic [ROWS-1:0] emp;
    logic [W-1:0]    dat;
    w_t              er;
    logic [ROWS-1:0] ev;
    bit              p;
    bit              ed;
    int              idx;
    inj_t            e;
    @(negedge i_clk);
    cyc++;
    for (int r = 0; r < ROWS; r++) begin
      emp[r] = (fq[r].size() == 0) || hold_empty[r];
      dat[r*DW +: DW] = (fq[r].size() != 0)
                      ? fq[r][0] : '0;
    end
    i_start     = st;
    i_num_vec   = n;
    i_stall     = sl;
    i_buf_empty = emp;
    i_buf_data  = dat;
    #1;
    p  = (m_mode == 1) && !sl && (emp == '0);
    er = '0;
    ev = '0;
    for (int r = 0; r < ROWS; r++) begin
      idx = hist.size() - 1 - r;
      if (idx >= 0) begin
        er[r*DW +: DW] = hist[idx].d[r*DW +: DW];
        ev[r] = hist[idx].v[r];
      end
    end
    ed = m_zero || (m_mode == 2 && m_dl == 1 && !sl);
    chk("rd", w_t'(o_buf_rd), w_t'({ROWS{p}}));
    chk("data", o_row_data, er);
    chk("valid", w_t'(o_row_valid), w_t'(ev));
    chk("busy", w_t'(o_busy), w_t'(m_mode != 0));
    chk("done", w_t'(o_done), w_t'(ed));
    if (o_done) begin
      done_cyc = cyc;
      done_cnt++;
    end
    if (o_buf_rd != '0) pops_seen++;
    if (!sl) begin
      e.v = {ROWS{p}};
      e.d = p ? dat : '0;
      hist.push_back(e);
      if (hist.size() > 8) void'(hist.pop_front());
      m_zero = (m_mode == 0) && st && (n == '0);
      case (m_mode)
        0: if (st && n != '0) begin
          m_mode = 1;
          m_left = int'(n);
        end
        1: if (p) begin
          m_left--;
          if (m_left == 0) begin
            m_mode = 2;
            m_dl   = ROWS;
          end
        end
        default: begin
          m_dl--;
          if (m_dl == 0) m_mode = 0;
        end
      endcase
      if (p)
        for (int r = 0; r < ROWS; r++)
          void'(fq[r].pop_front());
    end else begin
      m_zero = 1'b0;
    end
  endtask

  initial begin
    int s;
    @(negedge i_clk);
    chk("rst_rd", w_t'(o_buf_rd), '0);
    chk("rst_data", o_row_data, '0);
    chk("rst_valid", w_t'(o_row_valid), '0);
    chk("rst_busy", w_t'(o_busy), '0);
    chk("rst_done", w_t'(o_done), '0);
    @(negedge i_clk);
    i_rst = 1'b0;

    // basic run
    step(0, 0, 0);
    load(4);
    clr_obs();
    step(1, 4, 0);
    s = cyc;
    repeat (10) step(0, 0, 0);
    chk("s1_done_cyc", w_t'(done_cyc), w_t'(s + 7));
    chk("s1_done_cnt", w_t'(done_cnt), w_t'(1));
    chk("s1_pops", w_t'(pops_seen), w_t'(4));

    // bubble on row 1
    load(4);
    clr_obs();
    step(1, 4, 0);
    s = cyc;
    step(0, 0, 0);
    hold_empty = 3'b010;
    repeat (2) step(0, 0, 0);
    hold_empty = '0;
    repeat (10) step(0, 0, 0);
    chk("s2_done_cyc", w_t'(done_cyc), w_t'(s + 9));
    chk("s2_pops", w_t'(pops_seen), w_t'(4));

    // stall during drain
    load(4);
    clr_obs();
    step(1, 4, 0);
    s = cyc;
    repeat (4) step(0, 0, 0);
    repeat (3) step(0, 0, 1);
    repeat (8) step(0, 0, 0);
    chk("s3_done_cyc", w_t'(done_cyc), w_t'(s + 10));
    chk("s3_done_cnt", w_t'(done_cnt), w_t'(1));

    // zero vectors
    clr_obs();
    step(1, 0, 0);
    s = cyc;
    repeat (3) step(0, 0, 0);
    chk("s4_done_cyc", w_t'(done_cyc), w_t'(s + 1));
    chk("s4_done_cnt", w_t'(done_cnt), w_t'(1));
    chk("s4_pops", w_t'(pops_seen), w_t'(0));

    // start while busy
    load(4);
    clr_obs();
    step(1, 4, 0);
    s = cyc;
    step(0, 0, 0);
    step(1, 7, 0);
    repeat (10) step(0, 0, 0);
    chk("s5_pops", w_t'(pops_seen), w_t'(4));
    chk("s5_done_cyc", w_t'(done_cyc), w_t'(s + 7));

    // reset mid-feed after two pops
    load(4);
    step(1, 4, 0);
    repeat (2) step(0, 0, 0);
    @(negedge i_clk);
    cyc++;
    #2 i_rst = 1'b1;
    #1;
    chk("s6_rd", w_t'(o_buf_rd), '0);
    chk("s6_data", o_row_data, '0);
    chk("s6_valid", w_t'(o_row_valid), '0);
    chk("s6_busy", w_t'(o_busy), '0);
    chk("s6_done", w_t'(o_done), '0);
    hist.delete();
    m_mode = 0;
    m_zero = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
    clr_obs();
    step(1, 2, 0);
    s = cyc;
    repeat (8) step(0, 0, 0);
    chk("s6_pops", w_t'(pops_seen), w_t'(2));
    chk("s6_done_cyc", w_t'(done_cyc), w_t'(s + 5));
    chk("s6_fifo_left", w_t'(fq[0].size()), w_t'(0));

    // random traffic
    repeat (400) begin
      refill();
      for (int r = 0; r < ROWS; r++)
        hold_empty[r] = ($urandom % 6) == 0;
      step(($urandom % 8) == 0,
           CW'($urandom % 6),
           ($urandom % 5) == 0);
    end
    hold_empty = '0;
    repeat (40) begin
      refill();
      step(0, 0, 0);
    end
    chk("rand_idle", w_t'(o_busy), '0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
